// File: rtl/debounce_multi.sv
// N-channel switch debouncer: per-channel synchroniser, shared sample-tick prescaler,
// per-channel stability counter, debounced level plus one-cycle rise/fall pulses.
module debounce_multi #(
  parameter int   CH           = 4,
  parameter int   TICK_DIV     = 50000,
  parameter int   STABLE_TICKS = 10,
  parameter int   SYNC_STAGES  = 2,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] sw_dbnc,
  output logic [CH-1:0] sw_hi,
  output logic [CH-1:0] sw_lo,
  output logic          sw_any,
  output logic          tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_TICKS - 1);

  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] s;
  logic [CH-1:0] accept;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;
  logic [CW-1:0] cnt [CH];

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= {CH{RST_VAL}};
    end else begin
      sync_q[0] <= sw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    pcnt_nxt = (pcnt == PCNT_MAX) ? '0 : pcnt + PW'(1);
  end

  // tick is registered from the next count so it is high exactly while pcnt == TICK_DIV-1
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= pcnt_nxt;
      tick <= (pcnt_nxt == PCNT_MAX);
    end
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < CH; i++) begin
      accept[i] = tick && (s[i] != sw_dbnc[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Any cycle where the input matches the debounced level restarts that channel's count.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if ((s[i] == sw_dbnc[i]) || accept[i]) cnt[i] <= '0;
        else if (tick)                         cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      sw_dbnc <= {CH{RST_VAL}};
      sw_hi   <= '0;
      sw_lo   <= '0;
      sw_any  <= 1'b0;
    end else begin
      sw_dbnc <= (sw_dbnc & ~accept) | (s & accept);
      sw_hi   <= accept & s;
      sw_lo   <= accept & ~s;
      sw_any  <= |accept;
    end
  end

endmodule
